// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the scrolling 7-segment display driver.
//   - glyph code constants (GL_A .. GL_E, GL_BLANK)
//   - active-high segment patterns for each glyph (bit0 = a ... bit6 = g)
//   - glyph_to_seg(): code -> segment pattern, unknown codes render blank
//   - default_glyph(): power-up contents of a message buffer slot
// -----------------------------------------------------------------------------
package seg7_pkg;

  // Glyph codes as stored in the message buffer
  localparam logic [3:0] GL_A     = 4'd0;
  localparam logic [3:0] GL_B     = 4'd1;
  localparam logic [3:0] GL_D     = 4'd2;
  localparam logic [3:0] GL_U     = 4'd3;
  localparam logic [3:0] GL_L     = 4'd4;
  localparam logic [3:0] GL_DASH  = 4'd5;
  localparam logic [3:0] GL_J     = 4'd6;
  localparam logic [3:0] GL_O     = 4'd7;
  localparam logic [3:0] GL_S     = 4'd8;
  localparam logic [3:0] GL_E     = 4'd9;
  localparam logic [3:0] GL_BLANK = 4'd15;

  // Number of distinct printable glyphs; the reset pattern cycles through them
  localparam int NUM_GLYPHS = 10;

  // Segment patterns, active high, bit order g f e d c b a
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_U     = 7'b0111110;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_J     = 7'b0001110;
  localparam logic [6:0] SEG_O     = 7'b0111111;
  localparam logic [6:0] SEG_S     = 7'b1101101;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Codes 10..15 have no glyph and deliberately render as a dark digit
  function automatic logic [6:0] glyph_to_seg(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      GL_A:    pattern = SEG_A;
      GL_B:    pattern = SEG_B;
      GL_D:    pattern = SEG_D;
      GL_U:    pattern = SEG_U;
      GL_L:    pattern = SEG_L;
      GL_DASH: pattern = SEG_DASH;
      GL_J:    pattern = SEG_J;
      GL_O:    pattern = SEG_O;
      GL_S:    pattern = SEG_S;
      GL_E:    pattern = SEG_E;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  // Slot i powers up holding glyph (i mod 10), which spells "ABDUL-JOSE"
  function automatic logic [3:0] default_glyph(input int idx);
    return 4'(idx % NUM_GLYPHS);
  endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// -----------------------------------------------------------------------------
// seg7_glyph_dec
//   Purely combinational glyph decoder: 4-bit glyph code in, active-high
//   7-segment pattern out. Codes without a glyph decode to blank.
// Ports
//   code  in   4   glyph code
//   seg   out  7   segment pattern, bit0 = a ... bit6 = g, active high
// -----------------------------------------------------------------------------
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Decode table lives in the package so every user shares one definition
  always_comb begin
    seg = glyph_to_seg(code);
  end

endmodule

// File: rtl/seg7_scroll_mux.sv
// -----------------------------------------------------------------------------
// seg7_scroll_mux
//   Multiplexed multi-digit 7-segment driver that scrolls a writable message
//   of glyph codes across NUM_DIGITS physical digits.
//   - scan prescaler steps the lit digit every SCAN_DIV clocks
//   - scroll prescaler (gated by scroll_en) steps the message offset every
//     SCROLL_DIV enabled clocks; wrap pulses when the offset rolls over
//   - digit d shows buffer[(offset + d) mod MSG_LEN]
//   - seg/an are registered, so they reflect the state one clock earlier
// Parameters
//   NUM_DIGITS   physical digits scanned, an[0] = leftmost digit
//   MSG_LEN      message buffer entries (>= NUM_DIGITS)
//   SCAN_DIV     clocks per digit slot
//   SCROLL_DIV   enabled clocks per one-glyph scroll step
//   SEG_ACT_LOW  1: seg outputs inverted (common-anode)
//   AN_ACT_LOW   1: an outputs inverted
// Ports
//   clk        in   1           system clock, rising edge
//   rst        in   1           asynchronous active-high reset
//   scroll_en  in   1           scroll timer runs while high
//   wr_en      in   1           message buffer write strobe
//   wr_addr    in   ADDR_W      buffer index, out-of-range writes are dropped
//   wr_data    in   4           glyph code to write
//   seg        out  7           segments, bit0 = a ... bit6 = g
//   an         out  NUM_DIGITS  one-hot digit enable
//   wrap       out  1           one-cycle pulse when offset wraps to 0
// -----------------------------------------------------------------------------
module seg7_scroll_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 10,
  parameter int SCAN_DIV    = 50_000,
  parameter int SCROLL_DIV  = 25_000_000,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b0,
  localparam int ADDR_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scroll_en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [3:0]            wr_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  wrap
);

  // Counter widths derived from each counter's limit
  localparam int SCAN_W   = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OFF_W    = ADDR_W;
  // offset + digit is below 2*MSG_LEN, so one extra bit holds the raw sum
  localparam int IDX_W    = $clog2(2 * MSG_LEN);

  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [DIG_W-1:0]    DIG_LAST    = DIG_W'(NUM_DIGITS - 1);
  localparam logic [OFF_W-1:0]    OFF_LAST    = OFF_W'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0]    IDX_LEN     = IDX_W'(MSG_LEN);

  logic [SCAN_W-1:0]   scan_cnt;
  logic [SCROLL_W-1:0] scroll_cnt;
  logic [DIG_W-1:0]    digit;
  logic [OFF_W-1:0]    offset;
  logic [3:0]          buffer [MSG_LEN];

  logic                  scan_tick;
  logic                  scroll_tick;
  logic                  wr_ok;
  logic [IDX_W-1:0]      idx_sum;
  logic [IDX_W-1:0]      idx_mod;
  logic [3:0]            cur_code;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_hot;

  assign scan_tick   = (scan_cnt == SCAN_LAST);
  assign scroll_tick = scroll_en && (scroll_cnt == SCROLL_LAST);
  // Compare at integer width so a power-of-two MSG_LEN cannot alias to zero
  assign wr_ok       = wr_en && (int'(wr_addr) < MSG_LEN);

  // Scan prescaler and digit counter free-run; the digit steps on each
  // scan tick and rolls over after the last physical digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      digit    <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Scroll prescaler holds its count while scroll_en is low, so pausing
  // and resuming does not lose the partial interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_cnt <= '0;
      offset     <= '0;
    end else if (scroll_tick) begin
      scroll_cnt <= '0;
      offset     <= (offset == OFF_LAST) ? '0 : offset + 1'b1;
    end else if (scroll_en) begin
      scroll_cnt <= scroll_cnt + 1'b1;
    end
  end

  // Message buffer: reset restores the default message, host writes land
  // on the clock edge and are dropped when the address is out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        buffer[i] <= default_glyph(i);
      end
    end else if (wr_ok) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_addr == OFF_W'(i)) begin
          buffer[i] <= wr_data;
        end
      end
    end
  end

  // Buffer index for the current digit. The sum is always below
  // 2*MSG_LEN, so one conditional subtract replaces a modulo divider.
  always_comb begin
    idx_sum = IDX_W'(offset) + IDX_W'(digit);
    idx_mod = (idx_sum >= IDX_LEN) ? idx_sum - IDX_LEN : idx_sum;
  end

  // Read mux over the buffer; compare-select avoids indexing with a value
  // wider than the array range.
  always_comb begin
    cur_code = GL_BLANK;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx_mod == IDX_W'(i)) begin
        cur_code = buffer[i];
      end
    end
  end

  // One-hot enable for the digit currently being scanned
  always_comb begin
    an_hot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit == DIG_W'(i)) begin
        an_hot[i] = 1'b1;
      end
    end
  end

  seg7_glyph_dec u_dec (
    .code (cur_code),
    .seg  (dec_seg)
  );

  // Output register: polarity is applied after decode, and during reset the
  // display is dark in whichever polarity the board uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg  <= SEG_ACT_LOW ? 7'h7F : 7'h00;
      an   <= AN_ACT_LOW ? '1 : '0;
      wrap <= 1'b0;
    end else begin
      seg  <= SEG_ACT_LOW ? ~dec_seg : dec_seg;
      an   <= AN_ACT_LOW ? ~an_hot : an_hot;
      wrap <= scroll_tick && (offset == OFF_LAST);
    end
  end

endmodule
